detect_event_logger: RTL
========================

# detect_event_logger

Downstream consumer of the 01110 sequence detector's `Z` output. Each detection pulse is timestamped with a free-running cycle counter and the timestamp is queued in a small FIFO. The FIFO is drained through a valid/ready interface, so a host or testbench monitor can collect detection events without missing any while it stalls. Events that arrive while the FIFO is full are counted and flagged, never silently lost.

## Interface
- `TS_W`, default 16: timestamp width; free-running counter width.
- `DEPTH`, default 4: FIFO entries; power of two, ≥2.
- `CNT_W`, default 8: width of the saturating drop counter.
- `clk`  in  1: single clock; all logic on rising edge.
- `clr`  in  1: asynchronous, active-low reset.
- `en`  in  1: 1 = timestamp advances and `z_in` is sampled; 0 = both frozen.
- `z_in`  in  1: detection pulse, wired directly to the detector's `Z`.
- `evt_valid`  out  1: FIFO non-empty; head entry presented.
- `evt_ready`  in  1: consumer accepts head when `evt_valid && evt_ready` at a rising edge.
- `evt_ts`  out  TS_W: timestamp of head event.
- `evt_ovf`  out  1: one or more events were dropped immediately before this entry.
- `drop_cnt`  out  CNT_W: total dropped events, saturating.

## Operation
- Timestamp `ts`:
  - Increments by 1 each cycle while `en=1`.
  - Wraps from 2^TS_W−1 to 0; no wrap flag.
  - Held while `en=0`.
- Capture: on a rising edge with `en=1 && z_in=1`, the value of `ts` during that cycle is the event time.
  - If a slot is available, push {ts, drop_pending} and clear `drop_pending`.
  - Otherwise drop the event, set `drop_pending`, and increment `drop_cnt`, saturating at all-ones.
- Slot available means the FIFO is not full, or the FIFO is full and a pop occurs in the same cycle (pop frees a slot for a simultaneous push).
- Pop: `evt_valid && evt_ready` advances the read pointer.
  - Simultaneous push and pop leaves occupancy unchanged.
  - `evt_ready` while empty has no effect.
- FIFO storage:
  - Read/write pointers are log2(DEPTH)+1 bits; the extra bit distinguishes full from empty, and pointers wrap modulo 2·DEPTH.
  - Output is first-word-fall-through; the head entry is visible combinationally from memory.
- `evt_ts` and `evt_ovf` are forced to 0 whenever `evt_valid=0`.
- `en=0` does not block draining: pops continue normally.
- `z_in` held high for N consecutive cycles counts as N events, since every cycle is a capture. The detector's `Z` is a one-cycle Moore pulse, so this case should not arise in normal use.

## Timing
- Reset (asynchronous assert, synchronous-edge release) clears `ts=0`, both pointers to 0, `drop_pending=0`, `drop_cnt=0`.
  - Resulting outputs: `evt_valid=0`, `evt_ts=0`, `evt_ovf=0`, `drop_cnt=0`.
  - Takes effect immediately on `clr` falling, including mid-burst; all queued events are discarded.
- Latency: `z_in` sampled at edge k → `evt_valid=1` with that entry visible after edge k (one cycle).
- Consumer throughput: one event per cycle sustained.
- `drop_cnt` updates at the same edge as the drop.

## Configuration
- Macro `DETECT_LOG_DROPCNT_EN`.
  - Defined: the `drop_cnt` counter is built as described.
  - Undefined: no counter register exists and `drop_cnt` is tied to 0. `drop_pending` and `evt_ovf` behave identically in both builds.
  - The port list is unchanged between builds.

## Structure
- Shared header `detect_defs.vh` holds:
  - Detector state encodings.
  - Default `TS_W`, `DEPTH`, `CNT_W`.
  - FIFO entry field layout: `ovf` at the MSB, `ts` below.
- One sub-module, `evt_fifo`: parameterised synchronous FWFT FIFO (width, depth) with push/pop/full/empty.
- The top level holds the timestamp counter, drop logic and optional counter.

## Test plan
- Reset release, `en=1`, one `z_in` pulse sampled while `ts=5`, `evt_ready=1` → `evt_valid=1` for one cycle with `evt_ts=5`, `evt_ovf=0`; then empty.
- `DEPTH=4`, `evt_ready=0`, 6 pulses at ts=10..15 → FIFO holds ts 10..13, `drop_cnt=2`. Drain, then one pulse at ts=30 → drained entries 10..13 all have `evt_ovf=0`; the ts=30 entry has `evt_ovf=1`.
- FIFO full, `evt_ready=1` and `z_in=1` in the same cycle → push accepted, occupancy stays 4, `drop_cnt` unchanged.
- `TS_W=4`, pulses on consecutive cycles at ts=15 and ts=0 → entries read 15 then 0, in order.
- `en=0` for 5 cycles with `z_in` pulses → no pushes and `ts` frozen. Existing entries still drain.
- 3 entries queued, `clr` asserted mid-cycle → `evt_valid=0` and `drop_cnt=0` immediately, before the next edge. After release, next pulse is reported with `ts=0`-based timing.

Source files
------------

// File: rtl/detect_event_logger_pkg.sv
// Shared definitions for the detection event logger: detector state encoding,
// default geometry and FIFO entry layout ({ovf, ts}, ovf at the MSB).
package detect_event_logger_pkg;

  typedef enum logic [2:0] {
    DET_IDLE  = 3'd0,
    DET_0     = 3'd1,
    DET_01    = 3'd2,
    DET_011   = 3'd3,
    DET_0111  = 3'd4,
    DET_01110 = 3'd5
  } det_state_e;

  localparam int unsigned TS_W_DEF  = 16;
  localparam int unsigned DEPTH_DEF = 4;
  localparam int unsigned CNT_W_DEF = 8;

  function automatic int unsigned entry_width(input int unsigned ts_w);
    return ts_w + 1;
  endfunction

endpackage

// File: rtl/detect_event_logger_evt_fifo.sv
// Synchronous first-word-fall-through FIFO; pointers carry one extra bit so
// full and empty are distinguishable. A pop frees a slot for a same-cycle push.
module evt_fifo #(
  parameter int unsigned WIDTH = 17,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]      wptr_q, rptr_q;
  logic [AW:0]      wptr_d, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/detect_event_logger.sv
// Timestamps detector Z pulses into an FWFT FIFO drained by valid/ready.
// Define DETECT_LOG_DROPCNT_EN to build the saturating drop counter.
module detect_event_logger
  import detect_event_logger_pkg::*;
#(
  parameter int unsigned TS_W  = TS_W_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             z_in,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [TS_W-1:0]  evt_ts,
  output logic             evt_ovf,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int unsigned EW = entry_width(TS_W);

  logic [TS_W-1:0] ts_q, ts_d;
  logic            pend_q, pend_d;
  logic [EW-1:0]   head;
  logic            full, empty;
  logic            capture, pop, slot, push, drop;

  assign capture = en && z_in;
  assign pop     = evt_valid && evt_ready;
  assign slot    = !full || pop;
  assign push    = capture && slot;
  assign drop    = capture && !slot;

  evt_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (clr),
    .push_i  (push),
    .wdata_i ({pend_q, ts_q}),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign evt_valid = !empty;
  assign evt_ts    = evt_valid ? head[TS_W-1:0] : '0;
  assign evt_ovf   = evt_valid && head[EW-1];

  always_comb begin
    ts_d   = ts_q;
    pend_d = pend_q;
    if (en)   ts_d   = ts_q + 1'b1;
    if (push) pend_d = 1'b0;
    if (drop) pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      ts_q   <= '0;
      pend_q <= 1'b0;
    end else begin
      ts_q   <= ts_d;
      pend_q <= pend_d;
    end
  end

`ifdef DETECT_LOG_DROPCNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (drop && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign drop_cnt = cnt_q;
`else
  assign drop_cnt = '0;
`endif

endmodule
